// File: rtl/cscv3_pkg.sv
// cscv3_pkg: shared constants for the cscv3 core.
//   - opcode constants (instruction bits [AW+3:AW])
//   - ALU operation constants (opc[2:0] when opc[3] is set)
//   - FSM state encoding (FETCH=0, EXEC=1, MEM=2)
//   - flag bit indices inside {N,Z,V,C}
package cscv3_pkg;

   localparam logic [3:0] OpNop  = 4'd0;
   localparam logic [3:0] OpLdai = 4'd1;
   localparam logic [3:0] OpLdbi = 4'd2;
   localparam logic [3:0] OpLda  = 4'd3;
   localparam logic [3:0] OpSta  = 4'd4;
   localparam logic [3:0] OpJz   = 4'd5;
   localparam logic [3:0] OpJc   = 4'd6;
   localparam logic [3:0] OpJmp  = 4'd7;

   localparam logic [2:0] AluAdd   = 3'd0;
   localparam logic [2:0] AluSub   = 3'd1;
   localparam logic [2:0] AluAdc   = 3'd2;
   localparam logic [2:0] AluAnd   = 3'd3;
   localparam logic [2:0] AluOr    = 3'd4;
   localparam logic [2:0] AluXor   = 3'd5;
   localparam logic [2:0] AluInc   = 3'd6;
   localparam logic [2:0] AluPassB = 3'd7;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StExec  = 2'd1,
      StMem   = 2'd2
   } state_e;

   localparam int unsigned FlagC = 0;
   localparam int unsigned FlagV = 1;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagN = 3;

   // Opcodes 8..15 are all ALU instructions.
   function automatic logic is_alu_op(input logic [3:0] opc);
      return opc[3];
   endfunction

   // Only these two opcodes need a data-memory cycle.
   function automatic logic is_mem_op(input logic [3:0] opc);
      return (opc == OpLda) || (opc == OpSta);
   endfunction

endpackage

// File: rtl/cscv3_if.sv
// cscv3_if: instruction and data memory req/ack buses of the cscv3 core.
//   imem_req/imem_addr (core->mem), imem_ack/imem_data (mem->core)
//   dmem_req/dmem_we/dmem_addr/dmem_wdata (core->mem), dmem_ack/dmem_rdata (mem->core)
// master = core side, slave = memory side.
interface cscv3_if #(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 8
) ();

   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [AW+3:0] imem_data;

   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/cscv3_alu.sv
// cscv3_alu: combinational ALU of the cscv3 core.
//   a, b    : DW-bit operands (A and B registers)
//   op      : ALU operation (see cscv3_pkg Alu* constants)
//   cin     : carry flag input, used by ADC only
//   result  : DW-bit result, modulo 2^DW
//   flags   : {N,Z,V,C}
module cscv3_alu
   import cscv3_pkg::*;
#(
   parameter int unsigned DW = 4
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [2:0]    op,
   input  logic          cin,
   output logic [DW-1:0] result,
   output logic [3:0]    flags
);

   logic [DW:0]   sum;
   logic [DW-1:0] res;
   logic          carry;
   logic          ovf;

   always_comb begin
      sum   = '0;
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         AluAdd: begin
            sum   = {1'b0, a} + {1'b0, b};
            res   = sum[DW-1:0];
            carry = sum[DW];
            ovf   = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
         end
         AluSub: begin
            // Zero-extended subtraction: the top bit is the borrow (a < b).
            sum   = {1'b0, a} - {1'b0, b};
            res   = sum[DW-1:0];
            carry = sum[DW];
            ovf   = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
         end
         AluAdc: begin
            sum   = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            res   = sum[DW-1:0];
            carry = sum[DW];
            ovf   = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
         end
         AluAnd:  res = a & b;
         AluOr:   res = a | b;
         AluXor:  res = a ^ b;
         AluInc: begin
            sum   = {1'b0, a} + {{DW{1'b0}}, 1'b1};
            res   = sum[DW-1:0];
            carry = sum[DW];
            ovf   = !a[DW-1] && res[DW-1];
         end
         default: res = b;
      endcase
   end

   always_comb begin
      result       = res;
      flags        = '0;
      flags[FlagN] = res[DW-1];
      flags[FlagZ] = (res == '0);
      flags[FlagV] = ovf;
      flags[FlagC] = carry;
   end

endmodule

// File: rtl/cscv3_core.sv
// cscv3_core: parametrised multi-cycle CPU core with FETCH/EXEC/MEM FSM.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : cscv3_if.master, instruction and data req/ack buses
//   Aval, Bval : A and B registers (DW bits)
//   PCval      : program counter (AW bits)
//   Flagsval   : {N,Z,V,C}
//   state      : FSM state, FETCH=0, EXEC=1, MEM=2
module cscv3_core
   import cscv3_pkg::*;
#(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   cscv3_if.master       bus,
   output logic [DW-1:0] Aval,
   output logic [DW-1:0] Bval,
   output logic [AW-1:0] PCval,
   output logic [3:0]    Flagsval,
   output logic [1:0]    state
);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW+3:0] ir_q, ir_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [3:0]    flags_q, flags_d;

   logic [3:0]    opc;
   logic [AW-1:0] operand;
   logic [DW-1:0] alu_res;
   logic [3:0]    alu_flags;

   assign opc     = ir_q[AW+3:AW];
   assign operand = ir_q[AW-1:0];

   cscv3_alu #(
      .DW(DW)
   ) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (opc[2:0]),
      .cin    (flags_q[FlagC]),
      .result (alu_res),
      .flags  (alu_flags)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state. Acks only matter in the state that requests them.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: if (bus.imem_ack) state_d = StExec;
         StExec:  state_d = is_mem_op(opc) ? StMem : StFetch;
         StMem:   if (bus.dmem_ack) state_d = StFetch;
         default: state_d = StFetch;
      endcase
   end

   // FSM outputs: requests depend on state only, addresses/data come from
   // registers that are frozen for the whole request.
   always_comb begin
      bus.imem_req   = (state_q == StFetch);
      bus.imem_addr  = pc_q;
      bus.dmem_req   = (state_q == StMem);
      bus.dmem_we    = (state_q == StMem) && (opc == OpSta);
      bus.dmem_addr  = operand;
      bus.dmem_wdata = a_q;
   end

   // Datapath next state.
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      flags_d = flags_q;
      unique case (state_q)
         StFetch: begin
            if (bus.imem_ack) begin
               ir_d = bus.imem_data;
               pc_d = pc_q + AW'(1);
            end
         end
         StExec: begin
            if (is_alu_op(opc)) begin
               a_d     = alu_res;
               flags_d = alu_flags;
            end else begin
               case (opc)
                  OpLdai: a_d = operand[DW-1:0];
                  OpLdbi: b_d = operand[DW-1:0];
                  OpJz:   if (flags_q[FlagZ]) pc_d = operand;
                  OpJc:   if (flags_q[FlagC]) pc_d = operand;
                  OpJmp:  pc_d = operand;
                  default: ;
               endcase
            end
         end
         StMem: begin
            if (bus.dmem_ack && (opc == OpLda)) a_d = bus.dmem_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         flags_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         flags_q <= flags_d;
      end
   end

   assign Aval     = a_q;
   assign Bval     = b_q;
   assign PCval    = pc_q;
   assign Flagsval = flags_q;
   assign state    = state_q;

endmodule

// File: tb/tb_cscv3_core.sv
// tb_cscv3_core: directed bench for cscv3_core (DW=4, AW=8) with a ROM/RAM
// model and scoreboards of expected fetch addresses and data accesses.
module tb_cscv3_core;
   import cscv3_pkg::*;

   localparam int unsigned DW = 4;
   localparam int unsigned AW = 8;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            cycles;
   } dacc_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cscv3_if #(.DW(DW), .AW(AW)) bus ();

   logic [DW-1:0] aval, bval;
   logic [AW-1:0] pcval;
   logic [3:0]    flagsval;
   logic [1:0]    st;

   cscv3_core #(
      .DW(DW),
      .AW(AW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .Aval     (aval),
      .Bval     (bval),
      .PCval    (pcval),
      .Flagsval (flagsval),
      .state    (st)
   );

   // Memory models.
   logic [AW+3:0] rom [256];
   logic [DW-1:0] ram [256];
   logic imem_ack_en = 1'b1;
   logic dack_en     = 1'b1;
   int   dwait_st    = 3;
   int   dwait_ld    = 0;
   int   dcnt;
   int   wr_cnt = 0;

   assign bus.imem_ack   = imem_ack_en;
   assign bus.imem_data  = rom[bus.imem_addr];
   assign bus.dmem_rdata = ram[bus.dmem_addr];
   assign bus.dmem_ack   = bus.dmem_req && dack_en &&
                           (dcnt >= (bus.dmem_we ? dwait_st : dwait_ld));

   always @(posedge clk or posedge reset) begin
      if (reset) dcnt <= 0;
      else if (bus.dmem_req && !bus.dmem_ack) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end

   always @(posedge clk) begin
      if (bus.dmem_req && bus.dmem_we && bus.dmem_ack) begin
         ram[bus.dmem_addr] <= bus.dmem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   // Scoreboards and counters.
   int    fq[$];
   dacc_t dq[$];
   dacc_t cur;
   logic  d_active = 1'b0;
   int    d_cycles = 0;
   int    fetch_done = 0;
   int    cyc_cnt = 0;
   int    checks = 0;
   int    failures = 0;
   int    wr_before;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: monitor handshakes at the negedge, then advance past posedge.
   task automatic cyc();
      @(negedge clk);
      if (!reset) begin
         if (bus.imem_req && bus.imem_ack) begin
            if (fq.size() == 0) chk("fetch_unexpected", fq.size(), 1);
            else chk("fetch_addr", {24'b0, bus.imem_addr}, fq.pop_front());
            fetch_done++;
         end
         if (bus.dmem_req) begin
            if (!d_active) begin
               if (dq.size() == 0) chk("dmem_unexpected", dq.size(), 1);
               else cur = dq.pop_front();
               d_active = 1'b1;
               d_cycles = 0;
            end
            d_cycles++;
            chk("dmem_we", {31'b0, bus.dmem_we}, {31'b0, cur.we});
            chk("dmem_addr", {24'b0, bus.dmem_addr}, {24'b0, cur.addr});
            chk("dmem_wdata", {28'b0, bus.dmem_wdata}, {28'b0, cur.wdata});
            if (bus.dmem_ack) begin
               chk("dmem_len", d_cycles, cur.cycles);
               d_active = 1'b0;
            end
         end
      end
      @(posedge clk);
      cyc_cnt++;
      #1;
   endtask

   task automatic run_fetches(input int n);
      int target = fetch_done + n;
      int b = 0;
      while (fetch_done < target && b < 200) begin
         cyc();
         b++;
      end
      chk("fetch_budget", fetch_done, target);
   endtask

   task automatic push_d(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int cycles);
      dacc_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.cycles = cycles;
      dq.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 12'h000;
      rom[8'h00] = 12'h107;  // LDAI 7
      rom[8'h01] = 12'h209;  // LDBI 9
      rom[8'h02] = 12'h800;  // ADD
      rom[8'h03] = 12'h520;  // JZ 0x20
      rom[8'h20] = 12'h105;  // LDAI 5
      rom[8'h21] = 12'h440;  // STA 0x40
      rom[8'h22] = 12'h103;  // LDAI 3
      rom[8'h23] = 12'h340;  // LDA 0x40
      rom[8'h24] = 12'hE00;  // INC
      rom[8'h25] = 12'h510;  // JZ 0x10 (not taken)
      rom[8'h26] = 12'h207;  // LDBI 7
      rom[8'h27] = 12'h900;  // SUB
      rom[8'h28] = 12'h680;  // JC 0x80
      rom[8'h80] = 12'h7FF;  // JMP 0xFF
      rom[8'hFF] = 12'h000;  // NOP

      // Reset state.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {30'b0, st}, 0);
      chk("rst_imem_req", {31'b0, bus.imem_req}, 1);
      chk("rst_imem_addr", {24'b0, bus.imem_addr}, 0);
      chk("rst_dmem_req", {31'b0, bus.dmem_req}, 0);
      chk("rst_a", {28'b0, aval}, 0);
      chk("rst_b", {28'b0, bval}, 0);
      chk("rst_flags", {28'b0, flagsval}, 0);
      chk("rst_pc", {24'b0, pcval}, 0);

      fq.push_back('h00); fq.push_back('h01); fq.push_back('h02); fq.push_back('h03);
      reset   = 1'b0;
      cyc_cnt = 0;
      run_fetches(3);
      cyc();
      chk("add_cycles", cyc_cnt, 6);
      chk("add_pc", {24'b0, pcval}, 3);
      chk("add_a", {28'b0, aval}, 0);
      chk("add_b", {28'b0, bval}, 9);
      chk("add_flags", {28'b0, flagsval}, 4'b0101);
      chk("add_state", {30'b0, st}, 0);

      // JZ taken.
      run_fetches(1);
      cyc();
      chk("jz_taken_addr", {24'b0, bus.imem_addr}, 'h20);

      for (int i = 'h20; i <= 'h28; i++) fq.push_back(i);
      push_d(1'b1, 8'h40, 4'h5, 4);
      push_d(1'b0, 8'h40, 4'h3, 1);
      run_fetches(5);
      chk("lda_a", {28'b0, aval}, 5);
      chk("sta_writes", wr_cnt, 1);
      chk("lda_flags_kept", {28'b0, flagsval}, 4'b0101);

      run_fetches(2);
      chk("inc_a", {28'b0, aval}, 6);
      chk("inc_flags", {28'b0, flagsval}, 0);
      chk("jz_fall_pc", {24'b0, pcval}, 'h27);

      run_fetches(2);
      chk("sub_a", {28'b0, aval}, 'hF);
      chk("sub_b", {28'b0, bval}, 7);
      chk("sub_flags", {28'b0, flagsval}, 4'b1001);

      fq.push_back('h80); fq.push_back('hFF); fq.push_back('h00);
      run_fetches(1);
      chk("jc_taken_pc", {24'b0, pcval}, 'h81);
      run_fetches(1);
      chk("pc_wrap", {24'b0, pcval}, 0);
      run_fetches(1);
      chk("after_wrap_pc", {24'b0, pcval}, 1);
      chk("fetch_q_drained", fq.size(), 0);
      chk("dmem_q_drained", dq.size(), 0);

      // Reset during MEM of an STA with ack withheld.
      reset = 1'b1;
      #1;
      fq.delete();
      dq.delete();
      d_active = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 12'h000;
      rom[8'h00] = 12'h105;  // LDAI 5
      rom[8'h01] = 12'h450;  // STA 0x50
      dack_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      fq.push_back('h00); fq.push_back('h01);
      push_d(1'b1, 8'h50, 4'h5, 0);
      run_fetches(2);
      repeat (3) cyc();
      chk("mem_state", {30'b0, st}, 2);
      chk("mem_req_held", {31'b0, bus.dmem_req}, 1);
      chk("mem_we_held", {31'b0, bus.dmem_we}, 1);
      wr_before = wr_cnt;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_dmem_req", {31'b0, bus.dmem_req}, 0);
      chk("arst_dmem_we", {31'b0, bus.dmem_we}, 0);
      chk("arst_pc", {24'b0, pcval}, 0);
      chk("arst_state", {30'b0, st}, 0);
      chk("arst_a", {28'b0, aval}, 0);
      @(posedge clk);
      #1;
      chk("arst_no_write", wr_cnt, wr_before);
      d_active = 1'b0;
      dq.delete();
      dack_en = 1'b1;
      reset   = 1'b0;
      fq.delete();
      fq.push_back('h00);
      chk("post_rst_imem_req", {31'b0, bus.imem_req}, 1);
      chk("post_rst_dmem_req", {31'b0, bus.dmem_req}, 0);
      chk("post_rst_addr", {24'b0, bus.imem_addr}, 0);
      run_fetches(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cscv3_core.md
# cscv3_core

Parametrised multi-cycle successor to the Crazy Small CPU core. It has a configurable data width (DW) and address width (AW), an A/B register pair and a four-flag register. Instruction and data memories sit outside the block and are reached over req/ack handshakes, so wait-stated ROM or RAM works. Unlike the single-cycle core, it has an explicit FETCH/EXEC/MEM state machine, conditional jumps on zero and carry, and an asynchronous reset.

## Interface
- DW, 4: data/register width, ≥2.
- AW, 8: address width (PC, instruction operand, data address), ≥DW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address (= PC).
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  4+AW  instruction {opc[3:0], operand[AW-1:0]}.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  AW  data address (= operand).
- dmem_wdata  out  DW  write data (= A).
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle on reads.
- dmem_rdata  in  DW  read data.
- Aval, Bval  out  DW  A and B registers.
- PCval  out  AW  program counter.
- Flagsval  out  4  {N,Z,V,C}; C is bit 0.
- state  out  2  FETCH=0, EXEC=1, MEM=2.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LDAI: A←operand[DW-1:0].
  - 2 LDBI: B←operand[DW-1:0].
  - 3 LDA: A←mem[operand].
  - 4 STA: mem[operand]←A.
  - 5 JZ: jump if Z.
  - 6 JC: jump if C.
  - 7 JMP: PC←operand.
  - 8–15 ALU, with aluop=opc[2:0]; result goes to A and flags are updated.
- ALU ops:
  - 0 ADD A+B.
  - 1 SUB A−B.
  - 2 ADC A+B+C.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 INC A+1.
  - 7 PASSB (A←B).
- Flags:
  - Z = result==0.
  - N = result[DW-1].
  - C = carry-out for ADD, ADC and INC; C = borrow (A<B unsigned) for SUB; C = 0 for logical ops and PASSB.
  - V = signed overflow for ADD, SUB, ADC and INC; V = 0 otherwise.
  - Only ALU instructions write flags. All arithmetic is modulo 2^DW.
- FSM:
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR←imem_data, PC←PC+1 (mod 2^AW), go to EXEC.
  - EXEC: decode IR. Opcodes 3 and 4 go to MEM; every other opcode completes here and returns to FETCH. A taken jump overrides the incremented PC.
  - MEM: dmem_req=1; dmem_we=1 only for STA; dmem_addr and dmem_wdata are held stable. On dmem_ack: for LDA, A←dmem_rdata; go to FETCH.
- Request rules:
  - A req stays high with constant address and data until ack.
  - req is combinational from state, never from ack.
  - Ack arriving without req is ignored.
- Reset values: A=B=0, PC=0, Flags=0, IR=0, state=FETCH. imem_req is therefore 1 immediately after reset release.

## Timing
- With zero-wait memory (ack in the same cycle as req):
  - non-memory instructions take 2 cycles;
  - LDA and STA take 3 cycles.
- Each extra wait cycle on either port adds exactly one cycle.
- Register, PC and flag updates become visible on the clock edge ending EXEC or MEM.
- Reset asserted mid-cycle:
  - all outputs go to reset values immediately, without waiting for a clock;
  - dmem_req and dmem_we drop in that cycle;
  - an in-flight access is abandoned, with no write committed by the core.
- PC wraps from 2^AW−1 to 0. A jump to self spins with no special handling.

## Structure
- Shared package cscv3_pkg holds:
  - opcode constants;
  - ALU op constants;
  - state encodings;
  - flag bit indices (C=0, V=1, Z=2, N=3).
- One sub-module, cscv3_alu: combinational, parameter DW. Inputs a, b, op, cin; outputs result and flags.
- The top level contains only the FSM, registers, IR and decode.

## Test plan
- Reset, then release with imem_ack tied high → state=FETCH, imem_addr=0x00, A=B=Flags=0.
- Program LDAI 7; LDBI 9; ADD (DW=4) → A=0x0 with C=1, Z=1, N=0, V=0. PCval=3 after 6 cycles.
- Follow with JZ 0x20 → next imem_addr=0x20. A separate run with Z=0 falls through to the next address.
- STA 0x40 with A=5, dmem_ack delayed 3 cycles → dmem_req, dmem_we=1, addr 0x40 and wdata 5 held 4 cycles. Then LDA 0x40 with rdata=5 → A=5.
- JMP 0xFF; NOP at 0xFF → the fetch after NOP is at 0x00.
- Assert reset during MEM of an STA with ack withheld → dmem_req and dmem_we drop asynchronously, PC=0; the first request after release is a fetch at 0x00.
